// File: rtl/seven_seg_pkg.sv
// Shared types and glyph table for seven-segment display consumers.
// Segment order is [g,f,e,d,c,b,a] with a = bit 0, active low.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low glyph patterns for hex digits 0..F, indexed by nibble value.
  localparam seg_t SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } scan_state_t;

endpackage

// File: rtl/seg_glyph_to_hex.sv
// Combinational decode of an active-low seven-segment glyph to a hex nibble.
// legal is set only for the sixteen hex glyphs; is_blank flags the all-dark
// pattern so the consumer can decide whether blank is acceptable.
module seg_glyph_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       is_blank
);

  // Table search; the glyph patterns are unique so at most one entry matches.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == SEG_GLYPH[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

  assign is_blank = (seg_n == SEG_BLANK);

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Recovers the hex word shown on a multiplexed, active-low seven-segment
// display by watching its anode and segment lines.
// Optional build macro SEG_SCAN_READER_BLANK_EN: when defined the all-dark
// glyph is a legal "blank" digit; otherwise it is reported as a bad glyph and
// the blank output stays zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no anode low, or several low; nothing is being qualified
// SETTLE   | one anode low, counting identical consecutive samples
// CAPTURED | glyph accepted for this dwell, waiting for the lines to move
module seven_seg_scan_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    seg_err,
  output logic                    an_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(NUM_DIGITS);

`ifdef SEG_SCAN_READER_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  scan_state_t state, state_next;
  logic [CW-1:0] count, count_next;
  logic accept;

  logic [NUM_DIGITS-1:0]   prev_an_n;
  logic [6:0]              prev_seg_n;
  logic [4*NUM_DIGITS-1:0] digit_q, digit_next;
  logic [NUM_DIGITS-1:0]   seen_q, seen_next;
  logic [NUM_DIGITS-1:0]   dblank_q, dblank_next;
  logic                    frame_load;

  logic [NUM_DIGITS-1:0] an_low;
  logic                  multi_low;
  logic                  one_low;
  logic                  same;
  logic [IW-1:0]         idx;

  logic [3:0] g_nibble;
  logic       g_legal;
  logic       g_blank;
  logic       glyph_ok;

  assign an_low    = ~an_n;
  assign multi_low = |(an_low & (an_low - NUM_DIGITS'(1)));
  assign one_low   = (|an_low) && !multi_low;
  assign same      = (an_n == prev_an_n) && (seg_n == prev_seg_n);

  // Position of the single low anode; only meaningful when one_low is set.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) idx = IW'(i);
    end
  end

  seg_glyph_to_hex u_glyph (
    .seg_n    (seg_n),
    .nibble   (g_nibble),
    .legal    (g_legal),
    .is_blank (g_blank)
  );

  assign glyph_ok = g_legal | (BLANK_EN & g_blank);

  // Scan state and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Next state: acceptance fires once per dwell when the counter reaches the
  // threshold; afterwards the counter holds saturated until the lines change.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    if (!one_low) begin
      state_next = IDLE;
      count_next = '0;
    end else if (!same || state == IDLE) begin
      state_next = SETTLE;
      count_next = CW'(1);
    end else if (state == SETTLE) begin
      if (count == CW'(STABLE_CYCLES - 1)) begin
        accept     = 1'b1;
        state_next = CAPTURED;
        count_next = CW'(STABLE_CYCLES);
      end else begin
        count_next = count + CW'(1);
      end
    end
  end

  // Digit capture and frame assembly; a frame completed by this edge's
  // capture is published from digit_next so the newest nibble is included.
  always_comb begin
    digit_next  = digit_q;
    seen_next   = seen_q;
    dblank_next = dblank_q;
    frame_load  = &seen_q;
    if (accept) begin
      if (glyph_ok) begin
        digit_next[{idx, 2'b00} +: 4] = g_blank ? 4'h0 : g_nibble;
        dblank_next[idx]              = g_blank;
        seen_next[idx]                = 1'b1;
      end else begin
        seen_next[idx] = 1'b0;
      end
    end
    if (frame_load) seen_next = '0;
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_an_n   <= '0;
      prev_seg_n  <= '0;
      digit_q     <= '0;
      seen_q      <= '0;
      dblank_q    <= '0;
      value       <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      prev_an_n   <= an_n;
      prev_seg_n  <= seg_n;
      digit_q     <= digit_next;
      seen_q      <= seen_next;
      dblank_q    <= dblank_next;
      frame_valid <= frame_load;
      seg_err     <= accept & !glyph_ok;
      an_err      <= multi_low;
      if (frame_load) begin
        value <= digit_next;
        blank <= dblank_next & {NUM_DIGITS{BLANK_EN}};
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
- Receive side of the board's seven-segment display interface: watches multiplexed, active-low anode and segment lines and recovers the hex value being shown.
- Maps each stable glyph back to a 4-bit nibble and assembles a NUM_DIGITS-digit word.
- Flags glyphs that are not legal hex glyphs, and illegal anode states.
- Used for loopback self-check of display paths and for reading external 7-segment sources into the comparator datapath.

Parameters:
- NUM_DIGITS, 4, number of anodes/digits scanned; legal range 2-8.
- STABLE_CYCLES, 4, consecutive identical samples required before a glyph is accepted; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- an_n  input  NUM_DIGITS  anode enables, active low; bit 0 = far-right digit.
- seg_n  input  7  segment cathodes, active low, order [g,f,e,d,c,b,a]; a = bit 0.
- value  output  4*NUM_DIGITS  last complete frame; digit i occupies bits [4i+3:4i].
- frame_valid  output  1  one-cycle pulse when value updates.
- blank  output  NUM_DIGITS  per digit, 1 = digit was blank (7'h7F) in last frame.
- seg_err  output  1  one-cycle pulse: stable glyph not in hex table.
- an_err  output  1  one-cycle pulse: more than one anode low in a sample.

Behaviour:
- Reset (rst high at a clk edge): value=0, frame_valid=0, blank=0, seg_err=0, an_err=0; internal digit regs, seen mask, stability counter and previous-sample regs cleared; state IDLE. Reset wins over every other event.
- Inputs are sampled directly on clk with no synchroniser; they are same-domain by contract.
- Glyph table (seg_n to nibble), 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit). 7F = blank. Every other code is illegal.
- States:
  - IDLE: no anode low, or more than one anode low. Stay here and set count=0.
  - SETTLE: exactly one anode low.
    - If {an_n,seg_n} equals the previous sample, count increments.
    - Otherwise count=1 and the new sample is stored.
  - CAPTURED: glyph accepted for this dwell. No further capture until {an_n,seg_n} changes; any change goes to SETTLE with count=1, or to IDLE.
- Acceptance: a sample held identical on edges k..k+STABLE_CYCLES-1 is accepted at edge k+STABLE_CYCLES-1 (S=4: edges 0..3, accepted at edge 3). On acceptance:
  - Legal glyph: digit[idx]=nibble, blank bit for idx cleared, seen[idx]=1.
  - Blank glyph: digit[idx]=0, blank bit for idx set, seen[idx]=1.
  - Illegal glyph: digit unchanged, seen[idx]=0, seg_err pulses on the following cycle.
- Frame completion: when seen becomes all-ones, on the next edge:
  - value and blank load from the digit regs, frame_valid pulses, seen clears.
  - If the last digit is accepted on the same edge, its new nibble is included.
- More than one anode low in a sample: an_err pulses on the next cycle, state goes to IDLE, seen is unchanged.
- Same anode, changed glyph before acceptance: count restarts and no capture occurs. No partial-frame output is ever produced.
- The stability counter saturates at STABLE_CYCLES; it never wraps during a long dwell.
- All outputs are registered. The error pulses are mutually exclusive per cycle.

Optional Feature:
- Macro: SEG_SCAN_READER_BLANK_EN.
- When defined: blank glyph 7F is legal, with the behaviour above.
- When undefined: 7F is treated as an illegal glyph (seg_err pulses, seen bit cleared), and the blank output is tied to 0.

Decomposition:
- Package seven_seg_pkg:
  - typedef seg_t (logic [6:0]).
  - constants SEG_BLANK=7'h7F and SEG_GLYPH[16] (hex-digit patterns above).
  - enum scan_state_t {IDLE, SETTLE, CAPTURED}.
- One sub-module, seg_glyph_to_hex: purely combinational, seg_t in; nibble, legal and is_blank out. Shared with any future segment-consuming block.

Test Plan:
- Scan 4 digits, each held 6 cycles with glyphs 24,30,19,12 on an_n E,D,B,7 -> one frame_valid pulse, value=16'h5432, blank=0.
- Digit 0 held exactly STABLE_CYCLES-1 cycles, then changed -> no capture, no frame_valid, no errors.
- Glyph 7'h55 held stable on anode 1 -> seg_err pulses once; full frame requires a legal re-scan of digit 1 before frame_valid.
- an_n=4'b1100 for 1 cycle mid-scan -> an_err pulses once, state IDLE, earlier captured digits retained.
- With SEG_SCAN_READER_BLANK_EN, digit 3 = 7F and digits 0-2 = 0 -> value=16'h0000, blank=4'b1000. Without the macro, the same stimulus -> seg_err pulses and no frame.
- Assert rst after 3 of 4 digits are captured, then scan the full frame 0,1,2,3 -> value=16'h3210, no stale digits.
